led_source_arbiter: RTL and testbench

- Parametrised successor to the two-way LED colour mux.
- Selects one of NUM_SOURCES LED colour streams (ID shower, colour buffer, moving pixel, pattern generators, ...) and forwards it to the LED driver.
- Uses a valid/ready handshake and a registered output.
- Source changes take effect only on LED-frame boundaries, with an optional per-frame brightness fade-out/fade-in; an override input forces an immediate, unfaded switch at the next boundary.

---
 rtl/led_source_arbiter.sv | 175 +++++++++++++++++
 tb/tb_led_source_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_source_arbiter.sv
// Frame-synchronous LED colour source selector with valid/ready streaming,
// a registered output stage and per-frame brightness fade between sources.
module led_source_arbiter #(
    parameter int COLOR_WIDTH = 8,
    parameter int NUM_SOURCES = 4,
    parameter int NUM_LEDS    = 50,
    parameter int FADE_LOG2   = 2
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic [$clog2(NUM_SOURCES)-1:0]       sel_in,
    input  logic                                 override_in,
    input  logic [$clog2(NUM_SOURCES)-1:0]       override_src_in,
    input  logic [NUM_SOURCES*COLOR_WIDTH-1:0]   src_red_in,
    input  logic [NUM_SOURCES*COLOR_WIDTH-1:0]   src_green_in,
    input  logic [NUM_SOURCES*COLOR_WIDTH-1:0]   src_blue_in,
    input  logic [NUM_SOURCES-1:0]               src_valid_in,
    output logic [NUM_SOURCES-1:0]               src_ready_out,
    output logic [COLOR_WIDTH-1:0]               red_out,
    output logic [COLOR_WIDTH-1:0]               green_out,
    output logic [COLOR_WIDTH-1:0]               blue_out,
    output logic                                 color_valid_out,
    input  logic                                 color_ready_in,
    output logic                                 frame_done_out,
    output logic [$clog2(NUM_SOURCES)-1:0]       active_src_out,
    output logic [FADE_LOG2:0]                   fade_level_out
);

    localparam int SW   = $clog2(NUM_SOURCES);
    localparam int LW   = FADE_LOG2 + 1;
    localparam int PW   = COLOR_WIDTH + FADE_LOG2 + 1;
    localparam int CNTW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [LW-1:0]   L_MAX    = LW'(1 << FADE_LOG2);
    localparam logic [CNTW-1:0] LAST_PIX = CNTW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {ST_RUN, ST_FADE_OUT, ST_FADE_IN} state_t;

    state_t                 state_q;
    logic [SW-1:0]          active_q;
    logic [LW-1:0]          level_q;
    logic [CNTW-1:0]        cnt_q;
    logic [COLOR_WIDTH-1:0] red_q;
    logic [COLOR_WIDTH-1:0] green_q;
    logic [COLOR_WIDTH-1:0] blue_q;
    logic                   valid_q;
    logic                   done_q;

    logic                   ready;
    logic                   accept;
    logic                   boundary;
    logic [SW-1:0]          req_raw;
    logic [SW-1:0]          req;
    logic [LW-1:0]          level_up;
    logic [LW-1:0]          level_dn;
    logic [COLOR_WIDTH-1:0] cur_red;
    logic [COLOR_WIDTH-1:0] cur_green;
    logic [COLOR_WIDTH-1:0] cur_blue;

    function automatic logic [COLOR_WIDTH-1:0] scale(input logic [COLOR_WIDTH-1:0] c,
                                                     input logic [LW-1:0] l);
        logic [PW-1:0] prod;
        prod  = PW'(c) * PW'(l);
        scale = COLOR_WIDTH'(prod >> FADE_LOG2);
    endfunction

    assign ready    = !valid_q || color_ready_in;
    assign accept   = src_valid_in[active_q] && ready;
    assign boundary = accept && (cnt_q == LAST_PIX);

    assign cur_red   = src_red_in[active_q*COLOR_WIDTH +: COLOR_WIDTH];
    assign cur_green = src_green_in[active_q*COLOR_WIDTH +: COLOR_WIDTH];
    assign cur_blue  = src_blue_in[active_q*COLOR_WIDTH +: COLOR_WIDTH];

    // Out-of-range requests collapse to "stay on the current source".
    assign req_raw  = override_in ? override_src_in : sel_in;
    assign req      = ({1'b0, req_raw} < (SW+1)'(NUM_SOURCES)) ? req_raw : active_q;
    assign level_up = level_q + LW'(1);
    assign level_dn = level_q - LW'(1);

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_ready
            assign src_ready_out[gi] = ready && (active_q == SW'(gi));
        end
    endgenerate

    // Source/fade state machine; only moves on the last pixel of a frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_RUN;
            active_q <= '0;
            level_q  <= L_MAX;
        end else if (boundary) begin
            if (override_in) begin
                state_q  <= ST_RUN;
                active_q <= req;
                level_q  <= L_MAX;
            end else if (FADE_LOG2 == 0) begin
                active_q <= req;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (req != active_q) begin
                            level_q <= level_dn;
                            state_q <= ST_FADE_OUT;
                        end
                    end
                    ST_FADE_OUT: begin
                        if (req == active_q) begin
                            level_q <= level_up;
                            state_q <= (level_up == L_MAX) ? ST_RUN : ST_FADE_IN;
                        end else begin
                            level_q <= level_dn;
                            if (level_dn == '0) begin
                                active_q <= req;
                                state_q  <= ST_FADE_IN;
                            end
                        end
                    end
                    ST_FADE_IN: begin
                        if (req != active_q) begin
                            // Already black: retarget without going below zero.
                            if (level_q == '0) begin
                                active_q <= req;
                            end else begin
                                level_q <= level_dn;
                                if (level_dn == '0) begin
                                    active_q <= req;
                                end else begin
                                    state_q <= ST_FADE_OUT;
                                end
                            end
                        end else begin
                            level_q <= level_up;
                            if (level_up == L_MAX) begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= boundary;
            if (accept) begin
                red_q   <= scale(cur_red, level_q);
                green_q <= scale(cur_green, level_q);
                blue_q  <= scale(cur_blue, level_q);
                valid_q <= 1'b1;
                cnt_q   <= boundary ? '0 : cnt_q + CNTW'(1);
            end else if (color_ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign red_out         = red_q;
    assign green_out       = green_q;
    assign blue_out        = blue_q;
    assign color_valid_out = valid_q;
    assign frame_done_out  = done_q;
    assign active_src_out  = active_q;
    assign fade_level_out  = level_q;

endmodule

// File: tb/tb_led_source_arbiter.sv
// Randomised bench for led_source_arbiter against a frame-level brightness model.
module tb_led_source_arbiter;

    localparam int CW   = 8;
    localparam int NS   = 4;
    localparam int NL   = 4;
    localparam int FL   = 2;
    localparam int LMAX = 1 << FL;

    logic              clk = 1'b0;
    logic              clk_run = 1'b1;
    logic              rst_n = 1'b0;
    logic [1:0]        sel = '0;
    logic              override = 1'b0;
    logic [1:0]        ovr_src = '0;
    logic [NS*CW-1:0]  src_red = '0;
    logic [NS*CW-1:0]  src_green = '0;
    logic [NS*CW-1:0]  src_blue = '0;
    logic [NS-1:0]     src_valid = '0;
    logic [NS-1:0]     src_ready;
    logic [CW-1:0]     red;
    logic [CW-1:0]     green;
    logic [CW-1:0]     blue;
    logic              color_valid;
    logic              color_ready = 1'b1;
    logic              frame_done;
    logic [1:0]        active_src;
    logic [FL:0]       fade_level;

    int checks   = 0;
    int failures = 0;

    // Source-side stream state
    int s_r[NS];
    int s_g[NS];
    int s_b[NS];
    bit s_v[NS];
    bit consumed[NS];

    // Reference model state
    int m_active;
    int m_level;
    int m_count;
    bit m_valid;
    bit m_done;
    int m_r;
    int m_g;
    int m_b;

    led_source_arbiter #(
        .COLOR_WIDTH(CW),
        .NUM_SOURCES(NS),
        .NUM_LEDS(NL),
        .FADE_LOG2(FL)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .sel_in(sel),
        .override_in(override),
        .override_src_in(ovr_src),
        .src_red_in(src_red),
        .src_green_in(src_green),
        .src_blue_in(src_blue),
        .src_valid_in(src_valid),
        .src_ready_out(src_ready),
        .red_out(red),
        .green_out(green),
        .blue_out(blue),
        .color_valid_out(color_valid),
        .color_ready_in(color_ready),
        .frame_done_out(frame_done),
        .active_src_out(active_src),
        .fade_level_out(fade_level)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_color();
        case ($urandom_range(3))
            0:       return 8'hFF;
            1:       return 8'h00;
            2:       return 8'h80;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    function automatic int scaled(input int c, input int lvl);
        return (c * lvl) / LMAX;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_level  = LMAX;
        m_count  = 0;
        m_valid  = 1'b0;
        m_done   = 1'b0;
        m_r = 0;
        m_g = 0;
        m_b = 0;
        for (int i = 0; i < NS; i++) consumed[i] = 1'b0;
    endtask

    // Brightness walks toward zero while a different source is requested and
    // back up otherwise; reaching zero is the moment the source swaps.
    task automatic frame_update();
        int req;
        req = override ? int'(ovr_src) : int'(sel);
        if (req >= NS) req = m_active;
        if (override) begin
            m_active = req;
            m_level  = LMAX;
        end else if (req != m_active) begin
            if (FL == 0) begin
                m_active = req;
            end else begin
                m_level = (m_level > 0) ? m_level - 1 : 0;
                if (m_level == 0) m_active = req;
            end
        end else if (m_level < LMAX) begin
            m_level++;
        end
    endtask

    task automatic model_step();
        bit ready;
        bit last;
        ready = !m_valid || color_ready;
        if (s_v[m_active] && ready) begin
            m_r = scaled(s_r[m_active], m_level);
            m_g = scaled(s_g[m_active], m_level);
            m_b = scaled(s_b[m_active], m_level);
            m_valid = 1'b1;
            consumed[m_active] = 1'b1;
            last    = (m_count == NL - 1);
            m_done  = last;
            m_count = last ? 0 : m_count + 1;
            if (last) frame_update();
        end else begin
            if (m_valid && color_ready) m_valid = 1'b0;
            m_done = 1'b0;
        end
    endtask

    task automatic drive_inputs(input int cyc);
        for (int i = 0; i < NS; i++) begin
            if (!s_v[i] || consumed[i]) begin
                s_v[i] = ($urandom_range(3) != 0);
                s_r[i] = pick_color();
                s_g[i] = pick_color();
                s_b[i] = pick_color();
            end
            consumed[i] = 1'b0;
            src_red[i*CW +: CW]   = CW'(s_r[i]);
            src_green[i*CW +: CW] = CW'(s_g[i]);
            src_blue[i*CW +: CW]  = CW'(s_b[i]);
            src_valid[i]          = s_v[i];
        end
        color_ready = ($urandom_range(3) != 0);
        if (cyc > 100 && $urandom_range(29) == 0) sel = 2'($urandom_range(NS - 1));
        override = (cyc > 400) && ($urandom_range(39) == 0);
        ovr_src  = 2'($urandom_range(NS - 1));
    endtask

    task automatic check_outputs();
        int exp_ready;
        exp_ready = (!m_valid || color_ready) ? (1 << m_active) : 0;
        check_val("color_valid", int'(color_valid), int'(m_valid));
        check_val("red", int'(red), m_r);
        check_val("green", int'(green), m_g);
        check_val("blue", int'(blue), m_b);
        check_val("frame_done", int'(frame_done), int'(m_done));
        check_val("active_src", int'(active_src), m_active);
        check_val("fade_level", int'(fade_level), m_level);
        check_val("src_ready", int'(src_ready), exp_ready);
        if (m_valid && color_ready)
            $display("out rgb=%02h_%02h_%02h done=%0b src=%0d L=%0d t=%0t",
                     red, green, blue, frame_done, active_src, fade_level, $time);
    endtask

    // Asynchronous reset while the clock is parked low.
    task automatic do_reset();
        clk_run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #8;
        check_outputs();
        rst_n = 1'b1;
        #2;
        clk_run = 1'b1;
    endtask

    initial begin
        model_reset();
        drive_inputs(0);
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        model_step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            drive_inputs(cyc);
            @(negedge clk);
            check_outputs();
            if (cyc == 777 || cyc == 2011) do_reset();
            model_step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
